// File: rtl/secded_lock_pkg.sv
// Shared types and elaboration-time helpers for the key-locked SEC/DED pipeline.
// Used by locked_secded_pipe and secded_syndrome.
package secded_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        LOADING = 2'd1,
        ACTIVE  = 2'd2
    } lock_state_e;

    // Smallest number of Hamming check bits covering data_w data bits.
    function automatic int calc_p(input int data_w);
        int p;
        p = 0;
        for (int i = 31; i >= 1; i--) begin
            if ((1 << i) >= data_w + i + 1) p = i;
        end
        return p;
    endfunction

    function automatic logic is_pow2(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

    // Codeword position of data bit j: the j-th non-power-of-two position.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i < 1024; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == j && pos == 0) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational extended-Hamming checker: syndrome (XOR of set position indices)
// and overall parity of the whole codeword.
module secded_syndrome #(
    parameter int CODE_W = 22,
    parameter int P      = 5
) (
    input  logic [CODE_W-1:0] code,
    output logic [P-1:0]      s,
    output logic              p
);

    always_comb begin
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) s = s ^ P'(i);
        end
        p = ^code;
    end

endmodule

// File: rtl/locked_secded_pipe.sv
// Two-stage key-locked SEC/DED decoder with valid/ready on both sides.
// Optional macro SECDED_ERR_CNT_EN adds saturating sgl_cnt/dbl_cnt outputs.
module locked_secded_pipe
    import secded_lock_pkg::*;
#(
    parameter int              DATA_W      = 16,
    parameter int              KEY_W       = 32,
    parameter logic [KEY_W-1:0] KEY_CORRECT = 32'hA5C3_1E7F,
    localparam int             P           = calc_p(DATA_W),
    localparam int             CODE_W      = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic              key_bit,
    input  logic              key_clear,
    output logic              unlocked,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              sgl_err,
    output logic              dbl_err
`ifdef SECDED_ERR_CNT_EN
    ,
    output logic [15:0]       sgl_cnt,
    output logic [15:0]       dbl_cnt
`endif
);

    localparam int N  = CODE_W - 1;
    localparam int CW = $clog2(KEY_W + 1);

    // Handshake: a transfer happens on a clock edge where valid && ready;
    // valid never drops and payload never changes while waiting for ready.

    lock_state_e      state, state_nxt;
    logic [KEY_W-1:0] key_reg, key_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOCKED;
            key_reg <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            key_reg <= key_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_reg;
        cnt_nxt   = cnt;
        if (key_clear) begin
            state_nxt = LOCKED;
            key_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                LOCKED: begin
                    if (key_valid) begin
                        key_nxt[0] = key_bit;
                        cnt_nxt    = CW'(1);
                        state_nxt  = LOADING;
                    end
                end
                LOADING: begin
                    if (key_valid) begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt == CW'(i)) key_nxt[i] = key_bit;
                        end
                        cnt_nxt = cnt + CW'(1);
                        if (cnt == CW'(KEY_W - 1)) state_nxt = ACTIVE;
                    end
                end
                ACTIVE:  ;
                default: state_nxt = LOCKED;
            endcase
        end
    end

    assign unlocked = (state == ACTIVE);

    // Stage 1: data bits, syndrome and parity of the accepted codeword.
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [P-1:0]      s1_s;
    logic              s1_p;
    logic [DATA_W-1:0] code_data;
    logic [P-1:0]      syn_s;
    logic              syn_p;
    logic              s2_ready, s1_advance, accept;

    secded_syndrome #(.CODE_W(CODE_W), .P(P)) u_syndrome (
        .code (code_in),
        .s    (syn_s),
        .p    (syn_p)
    );

    assign s2_ready   = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_ready;
    assign in_ready   = (state == ACTIVE) && (!s1_valid || s1_advance);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_s     <= '0;
            s1_p     <= 1'b0;
        end else if (key_clear) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= code_data;
            s1_s     <= syn_s;
            s1_p     <= syn_p;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: classify, correct a flipped data position, then apply key mask.
    logic              flip_en, dec_sgl, dec_dbl;
    logic [DATA_W-1:0] fixed;
    logic [KEY_W-1:0]  mask;
    logic [DATA_W-1:0] fold;

    always_comb begin
        flip_en = 1'b0;
        dec_sgl = 1'b0;
        dec_dbl = 1'b0;
        if (s1_p) begin
            if (s1_s == '0) begin
                dec_sgl = 1'b1;
            end else if (s1_s <= P'(N)) begin
                flip_en = 1'b1;
                dec_sgl = 1'b1;
            end else begin
                dec_dbl = 1'b1;
            end
        end else if (s1_s != '0) begin
            dec_dbl = 1'b1;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        localparam int POS = data_pos(j);
        assign code_data[j] = code_in[POS];
        assign fixed[j]     = s1_data[j] ^ (flip_en && (s1_s == P'(POS)));
    end

    assign mask = key_reg ^ KEY_CORRECT;

    always_comb begin
        fold = '0;
        for (int j = 0; j < DATA_W; j++) begin
            for (int i = 0; i < KEY_W; i++) begin
                if ((i % DATA_W) == j) fold[j] = fold[j] ^ mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sgl_err   <= 1'b0;
            dbl_err   <= 1'b0;
        end else if (key_clear) begin
            out_valid <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= fixed ^ fold;
                sgl_err  <= dec_sgl;
                dbl_err  <= dec_dbl;
            end
        end
    end

`ifdef SECDED_ERR_CNT_EN
    logic transfer;
    assign transfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (key_clear) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else if (transfer) begin
            if (sgl_err && sgl_cnt != 16'hFFFF) sgl_cnt <= sgl_cnt + 16'd1;
            if (dbl_err && dbl_cnt != 16'hFFFF) dbl_cnt <= dbl_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_locked_secded_pipe.sv
// Self-checking bench for locked_secded_pipe: directed vector table, hand-written
// key/backpressure/reset sequences and randomized words against a brute-force model.
module tb_locked_secded_pipe;

    localparam int DATA_W = 16;
    localparam int P      = 5;
    localparam int CODE_W = 22;
    localparam int N      = 21;
    localparam int RW     = DATA_W + 2;
    localparam logic [31:0] KEY_OK = 32'hA5C3_1E7F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_valid = 1'b0;
    logic              key_bit = 1'b0;
    logic              key_clear = 1'b0;
    logic              unlocked;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CODE_W-1:0] code_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              sgl_err;
    logic              dbl_err;
`ifdef SECDED_ERR_CNT_EN
    logic [15:0]       sgl_cnt;
    logic [15:0]       dbl_cnt;
`endif

    locked_secded_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_bit   (key_bit),
        .key_clear (key_clear),
        .unlocked  (unlocked),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_in   (code_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .sgl_err   (sgl_err),
        .dbl_err   (dbl_err)
`ifdef SECDED_ERR_CNT_EN
        ,
        .sgl_cnt   (sgl_cnt),
        .dbl_cnt   (dbl_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int                checks = 0;
    int                errors = 0;
    int                stall_cycles = 0;
    logic [RW-1:0]     exp_q[$];
    logic [31:0]       cur_key = '0;
    logic              rand_ready_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if (!pow2(pos)) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; k < P; k++) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos <= N; pos++) begin
                if (((pos >> k) & 1) == 1 && pos != (1 << k)) par = par ^ c[pos];
            end
            c[1 << k] = par;
        end
        c[0] = ^c[N:1];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if (!pow2(pos)) begin
                d[j] = c[pos];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CODE_W-1:0] flip(input logic [CODE_W-1:0] c, input int pos);
        logic [CODE_W-1:0] r;
        r = c;
        r[pos] = ~r[pos];
        return r;
    endfunction

    // Nearest-codeword search: valid word -> clean; one flip away -> corrected; else double.
    function automatic logic [RW-1:0] ref_decode(input logic [CODE_W-1:0] r);
        if (encode(extract(r)) == r) return {extract(r), 1'b0, 1'b0};
        for (int k = 0; k < CODE_W; k++) begin
            if (encode(extract(flip(r, k))) == flip(r, k)) return {extract(flip(r, k)), 1'b1, 1'b0};
        end
        return {extract(r), 1'b0, 1'b1};
    endfunction

    function automatic logic [DATA_W-1:0] fold_mask(input logic [31:0] key);
        logic [31:0]       m;
        logic [DATA_W-1:0] f;
        m = key ^ KEY_OK;
        f = '0;
        for (int i = 0; i < 32; i++) f[i % DATA_W] = f[i % DATA_W] ^ m[i];
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        key_valid = 1'b1;
        key_bit   = b;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k);
        for (int i = 0; i < 32; i++) shift_bit(k[i]);
        cur_key = k;
    endtask

    task automatic clear_key();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        cur_key = '0;
    endtask

    task automatic send(input logic [CODE_W-1:0] c, input logic [RW-1:0] e);
        int w;
        w = 0;
        in_valid = 1'b1;
        code_in  = c;
        #1;
        while (!in_ready && w < 200) begin
            tick();
            #1;
            w++;
        end
        stall_cycles += w;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
            tick();
        end else begin
            @(posedge clk);
            exp_q.push_back(e);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int w;
        w = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && w < budget) begin
            tick();
            w++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic monitor();
        logic          prev_hold;
        logic [RW:0]   prev_out;
        logic [RW-1:0] e;
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (prev_hold && rst_n)
                check("hold_stable", 32'({out_valid, data_out, sgl_err, dbl_err}), 32'(prev_out));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({data_out, sgl_err, dbl_err}), 32'(e));
                end
            end
            prev_hold = out_valid && !out_ready && rst_n && !key_clear;
            prev_out  = {out_valid, data_out, sgl_err, dbl_err};
            if (!rst_n || key_clear) exp_q.delete();
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(negedge clk);
            if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // ---------------- directed tables ----------------
    typedef struct {
        logic [CODE_W-1:0] code;
        logic [DATA_W-1:0] data;
        logic              sgl;
        logic              dbl;
    } vec_t;

    typedef struct {
        logic [31:0]       key;
        logic [DATA_W-1:0] data;
    } key_vec_t;

    vec_t     vecs[7];
    key_vec_t kvecs[3];

    initial begin
        logic [CODE_W-1:0] c;
        logic [CODE_W-1:0] r;
        logic [DATA_W-1:0] d;
        logic [RW-1:0]     e;
        int                p1, p2, nerr;

        c = encode(16'h1234);
        vecs[0] = '{c,                                    16'h1234, 1'b0, 1'b0};
        vecs[1] = '{flip(c, 3),                           16'h1234, 1'b1, 1'b0};
        vecs[2] = '{flip(c, 0),                           16'h1234, 1'b1, 1'b0};
        vecs[3] = '{flip(flip(c, 3), 5),                  16'h1237, 1'b0, 1'b1};
        vecs[4] = '{flip(c, 4),                           16'h1234, 1'b1, 1'b0};
        vecs[5] = '{flip(c, 21),                          16'h1234, 1'b1, 1'b0};
        vecs[6] = '{flip(flip(flip(c, 16), 4), 2),        16'h1234, 1'b0, 1'b1};
        kvecs[0] = '{KEY_OK ^ 32'h0001_0001, 16'h1234};
        kvecs[1] = '{KEY_OK ^ 32'h0000_0001, 16'h1235};
        kvecs[2] = '{KEY_OK ^ 32'h0010_0000, 16'h1224};

        fork
            monitor();
            ready_driver();
        join_none

        // Reset state and locked behaviour
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_unlocked",  32'(unlocked),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_flags",     32'({sgl_err, dbl_err}), 32'd0);
        in_valid = 1'b1;
        code_in  = c;
        repeat (4) tick();
        check("nokey_in_ready",  32'(in_ready),  32'd0);
        check("nokey_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // Unlock timing
        for (int i = 0; i < 31; i++) shift_bit(KEY_OK[i]);
        check("unlock_31_bits", 32'(unlocked), 32'd0);
        shift_bit(KEY_OK[31]);
        cur_key = KEY_OK;
        check("unlock_32_bits", 32'(unlocked), 32'd1);
        out_ready = 1'b1;
        #1;
        check("unlock_in_ready", 32'(in_ready), 32'd1);

        // Latency of a clean word
        send(c, {16'h1234, 1'b0, 1'b0});
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_cycle2_data",  32'(data_out),  32'h1234);
        tick();

        // Error classification table, back to back
        stall_cycles = 0;
        for (int i = 0; i < 7; i++) send(vecs[i].code, {vecs[i].data, vecs[i].sgl, vecs[i].dbl});
        check("table_full_throughput", 32'(stall_cycles), 32'd0);
        drain(10);

        // Wrong keys
        for (int i = 0; i < 3; i++) begin
            clear_key();
            check("clear_unlocked", 32'(unlocked), 32'd0);
            load_key(kvecs[i].key);
            send(c, {kvecs[i].data, 1'b0, 1'b0});
            drain(10);
        end

        // Backpressure: 4 words while the sink stalls for 3 cycles
        clear_key();
        load_key(KEY_OK);
        out_ready = 1'b0;
        fork
            begin
                send(encode(16'hA001), {16'hA001, 1'b0, 1'b0});
                send(encode(16'hB002), {16'hB002, 1'b0, 1'b0});
                send(flip(encode(16'hC003), 9), {16'hC003, 1'b1, 1'b0});
                send(encode(16'hD004), {16'hD004, 1'b0, 1'b0});
            end
            begin
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain(10);

        // key_clear flushes in-flight words
        out_ready = 1'b0;
        send(encode(16'h1111), {16'h1111, 1'b0, 1'b0});
        send(encode(16'h2222), {16'h2222, 1'b0, 1'b0});
        clear_key();
        check("clear_flush_valid", 32'(out_valid), 32'd0);
        check("clear_in_ready",    32'(in_ready),  32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("clear_no_output", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        load_key(KEY_OK);
        out_ready = 1'b0;
        send(encode(16'h3333), {16'h3333, 1'b0, 1'b0});
        send(encode(16'h4444), {16'h4444, 1'b0, 1'b0});
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_unlocked",  32'(unlocked),  32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        cur_key = '0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        code_in = c;
        repeat (4) tick();
        check("arst_in_ready_locked", 32'(in_ready),  32'd0);
        check("arst_no_output",       32'(out_valid), 32'd0);
        in_valid = 1'b0;
        load_key(KEY_OK);
        #1;
        check("arst_reload_in_ready", 32'(in_ready), 32'd1);

        // Randomized words: correct key, then a random key
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                drain(20);
                clear_key();
                load_key($urandom);
            end
            rand_ready_en = 1'b1;
            for (int n = 0; n < 150; n++) begin
                d = 16'($urandom);
                r = encode(d);
                nerr = $urandom_range(0, 2);
                p1 = $urandom_range(0, CODE_W - 1);
                p2 = (p1 + $urandom_range(1, CODE_W - 1)) % CODE_W;
                if (nerr >= 1) r = flip(r, p1);
                if (nerr == 2) r = flip(r, p2);
                e = ref_decode(r);
                e[RW-1:2] = e[RW-1:2] ^ fold_mask(cur_key);
                send(r, e);
            end
            rand_ready_en = 1'b0;
            tick();
        end
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/locked_secded_pipe.md
Name: locked_secded_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational key-locked 16-bit SEC/DED benchmark.
- Decodes one extended-Hamming codeword per cycle: corrects single errors, flags double errors.
- Output data stays corrupted unless the serially loaded key matches the build-time correct key.
- Sits between a codeword source and a data sink with valid/ready on both sides; used as a sequential locking/attack benchmark.

Parameters:
- DATA_W, 16: data bits per codeword.
- KEY_W, 32: key length in bits.
- KEY_CORRECT, 32'hA5C3_1E7F: unlocking key, KEY_W bits.
- P (localparam): minimal integer with 2^P >= DATA_W+P+1; equals 5 at DATA_W=16.
- CODE_W (localparam): DATA_W+P+1; equals 22 at DATA_W=16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key bit strobe
- key_bit  in  1  serial key bit, LSB first
- key_clear  in  1  discard key, return to LOCKED
- unlocked  out  1  high in ACTIVE state
- in_valid  in  1  codeword valid
- in_ready  out  1  codeword accepted when in_valid&&in_ready
- code_in  in  CODE_W  bit 0 = overall parity; bits 1..CODE_W-1 = Hamming positions 1..N; check bits at power-of-two positions
- out_valid  out  1  result valid
- out_ready  in  1  sink ready
- data_out  out  DATA_W  corrected data, possibly key-masked; ascending non-power-of-two positions
- sgl_err  out  1  single error corrected
- dbl_err  out  1  uncorrectable error

Behaviour:
- Reset: state=LOCKED, key_reg=0, bit counter=0, both pipe stages invalid. Outputs all 0: unlocked, out_valid, data_out, flags, in_ready.
- FSM LOCKED -> LOADING on the first key_valid; that bit is shifted in and the counter set to 1.
- LOADING: each key_valid shifts key_bit into key_reg[cnt] and increments cnt. After bit KEY_W-1, next state is ACTIVE.
- key_clear in any state (priority over key_valid): key_reg=0, cnt=0, -> LOCKED.
- Pipeline state on key_clear: in-flight pipe contents are flushed (valids cleared) the same cycle.
- in_ready = (state==ACTIVE) && (!s1_valid || s1_advance). Stage advances when the downstream stage is empty or is being drained.
- Stage 1 registers code_in, syndrome s (XOR of indices of set positions 1..N) and overall parity p (XOR of all CODE_W bits).
- Stage 2 decode, p=0, s=0: clean; no flags.
- Stage 2 decode, p=1, s=0: parity bit error; sgl_err=1, data unchanged.
- Stage 2 decode, p=1, 1<=s<=N: flip position s; sgl_err=1.
- Stage 2 decode, p=1, s>N: dbl_err=1, no correction.
- Stage 2 decode, p=0, s!=0: dbl_err=1, no correction.
- Key mask: mask = key_reg ^ KEY_CORRECT. data_out = corrected ^ fold(mask), with fold bit j = XOR of mask[i] over all i where i mod DATA_W == j.
- Flags are never masked.
- Latency: 2 cycles from accept to out_valid.
- Backpressure: out_valid && !out_ready holds all outputs stable. Full throughput is 1 word/cycle.
- The mask is sampled at stage 2 from the current key_reg.

Optional Feature:
- Macro: SECDED_ERR_CNT_EN.
- Defined: adds outputs sgl_cnt[15:0] and dbl_cnt[15:0]. Each is a saturating counter (stops at 16'hFFFF) of transferred results with the matching flag. Counters clear on reset and on key_clear.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package secded_lock_pkg holds:
  - state enum {LOCKED, LOADING, ACTIVE};
  - function calc_p(DATA_W);
  - function is_pow2(idx);
  - function data_pos(j), returning the codeword position of data bit j.
- One sub-module, secded_syndrome: combinational; code_in -> {s, p}; instantiated in stage 1.

Test Plan:
- Unlock: after reset, shift KEY_CORRECT 32'hA5C3_1E7F LSB-first. Expect unlocked=1 the cycle after the 32nd bit, and in_ready rises. With no key loaded, in_ready stays 0.
- Clean word: encode 16'h1234, present it with out_ready=1. Two cycles later expect data_out=16'h1234, sgl_err=0, dbl_err=0.
- Single error: flip position 3 of the 16'h1234 codeword. Expect data_out=16'h1234, sgl_err=1. Separately flip bit 0: sgl_err=1, data unchanged.
- Double error: flip positions 3 and 5. Expect dbl_err=1, sgl_err=0, data_out = uncorrected extraction.
- Wrong key: load KEY_CORRECT^32'h0001_0001 (mask bits 0 and 16 cancel in the fold), expect data_out=16'h1234. Load KEY_CORRECT^32'h0000_0001, expect 16'h1235.
- Backpressure/reset: stream 4 words with out_ready low for 3 cycles; expect no loss or duplication and in order. Assert rst_n low mid-stream: out_valid=0 immediately and unlocked=0; in_ready stays 0 until the key is reloaded.
